// File: rtl/sd_rx_pkg.sv
// Shared constants for the sd_rx capture block: FSM state codes, err bit indices and
// default sizing. Optional checksum byte is enabled with macro SD_RX_CHECKSUM_EN.
package sd_rx_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StArmed = 3'd1;
    localparam logic [2:0] StReq   = 3'd2;
    localparam logic [2:0] StRecv  = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;

    localparam int unsigned ErrOvf = 0;
    localparam int unsigned ErrTmo = 1;

    localparam int unsigned DefDepth   = 32;
    localparam int unsigned DefTimeout = 1024;

endpackage

// File: rtl/sd_rx_buf.sv
// Capture storage for sd_rx: synchronous write port, combinational read port.
// Contents are not reset.
module sd_rx_buf
    import sd_rx_pkg::*;
#(
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sd_rx.sv
// Receive side of the trigger/send handshake: arms, requests a buffer, captures strobed
// bytes until cd or timeout, then drains them. Macro SD_RX_CHECKSUM_EN appends an XOR byte.
module sd_rx
    import sd_rx_pkg::*;
#(
    parameter int unsigned DEPTH   = DefDepth,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req,
    input  logic                   trd,
    output logic                   sbf,
    input  logic [8:0]             sd,
    input  logic                   cd,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] byte_cnt,
    output logic                   busy,
    output logic [1:0]             err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] Full    = CW'(DEPTH);
    localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT - 1);

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rd_q, rd_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    err_q, err_d;
    logic          wr_en, hs, last;
    logic [7:0]    rdata;
`ifdef SD_RX_CHECKSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    // Write address doubles as the byte count; a full buffer blocks the write.
    assign wr_en = (state_q == StRecv) && sd[8] && (cnt_q != Full);

    sd_rx_buf #(
        .DEPTH(DEPTH)
    ) u_buf (
        .clk  (clk),
        .we   (wr_en),
        .waddr(cnt_q[AW-1:0]),
        .wdata(sd[7:0]),
        .raddr(rd_q[AW-1:0]),
        .rdata(rdata)
    );

    always_comb begin
        out_valid = 1'b0;
        out_data  = 8'h00;
        last      = 1'b0;
`ifdef SD_RX_CHECKSUM_EN
        // One extra slot at rd == cnt carries the checksum.
        if (state_q == StDrain && rd_q <= cnt_q) begin
            out_valid = 1'b1;
            out_data  = (rd_q == cnt_q) ? csum_q : rdata;
            last      = (rd_q == cnt_q);
        end
`else
        if (state_q == StDrain && rd_q < cnt_q) begin
            out_valid = 1'b1;
            out_data  = rdata;
            last      = (rd_q + 1'b1 == cnt_q);
        end
`endif
    end

    assign hs       = out_valid && out_ready;
    assign sbf      = (state_q == StReq);
    assign busy     = (state_q != StIdle);
    assign byte_cnt = cnt_q;
    assign err      = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
`ifdef SD_RX_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (req) begin
                    state_d = StArmed;
                    cnt_d   = '0;
                    rd_d    = '0;
`ifdef SD_RX_CHECKSUM_EN
                    csum_d  = 8'h00;
`endif
                end
            end
            StArmed: begin
                if (trd) begin
                    state_d = StReq;
                    tmo_d   = '0;
                    err_d   = '0;
                end
            end
            StReq: state_d = StRecv;
            StRecv: begin
                if (sd[8]) begin
                    if (cnt_q != Full) begin
                        cnt_d  = cnt_q + 1'b1;
`ifdef SD_RX_CHECKSUM_EN
                        csum_d = csum_q ^ sd[7:0];
`endif
                    end else begin
                        err_d[ErrOvf] = 1'b1;
                    end
                end
                if (cd) begin
                    state_d = StDrain;
                end else if (tmo_q == TmoLast) begin
                    err_d[ErrTmo] = 1'b1;
                    state_d       = StDrain;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDrain: begin
                if (!out_valid || (hs && last)) begin
                    state_d = StIdle;
                end else if (hs) begin
                    rd_d = rd_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rd_q    <= '0;
            tmo_q   <= '0;
            err_q   <= '0;
`ifdef SD_RX_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`ifdef SD_RX_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule
